shot_resolver: RTL and testbench

SHOT_RESOLVER -- requirements
Module: shot_resolver

---
 rtl/shot_resolver_if.sv | 30 +++
 rtl/shot_resolver.sv | 110 +++++++++++
 tb/tb_shot_resolver.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shot_resolver_if.sv
// Shot resolver request, result and fleet memory signals.
// master drives requests and read data; slave is the resolver.
interface shot_resolver_if;
    logic        start;
    logic        jogador;
    logic [4:0]  tiro;
    logic [63:0] mem_rdata;
    logic [4:0]  mem_addr;
    logic        mem_sel;
    logic [63:0] mem_wdata;
    logic        mem_we;
    logic        busy;
    logic        done;
    logic        acerto;
    logic        afundou;
    logic        invalido;
    logic        jogador_out;

    modport master (
        output start, jogador, tiro, mem_rdata,
        input  mem_addr, mem_sel, mem_wdata, mem_we,
        input  busy, done, acerto, afundou, invalido, jogador_out
    );

    modport slave (
        input  start, jogador, tiro, mem_rdata,
        output mem_addr, mem_sel, mem_wdata, mem_we,
        output busy, done, acerto, afundou, invalido, jogador_out
    );
endinterface

// File: rtl/shot_resolver.sv
// Resolves one shot against the opponent fleet memory.
// Scans entries 0..11, clears matching cells, writes back on first hit.
module shot_resolver (
    input  logic            clk,
    input  logic            reset,
    shot_resolver_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        READ,
        WAIT,
        COMPARE,
        WRITE,
        FINISH
    } state_t;

    state_t      state;
    logic [4:0]  shot;
    logic        hit;
    logic [63:0] cleared;

    // Match the captured shot against every live cell of the current word
    always_comb begin
        hit     = 1'b0;
        cleared = bus.mem_rdata;
        for (int k = 0; k < 8; k++) begin
            if (bus.mem_rdata[3+5*k +: 5] != 5'd0 &&
                bus.mem_rdata[3+5*k +: 5] == shot) begin
                hit                 = 1'b1;
                cleared[3+5*k +: 5] = 5'd0;
            end
        end
    end

    // Control FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            shot            <= 5'd0;
            bus.mem_addr    <= 5'd0;
            bus.mem_we      <= 1'b0;
            bus.mem_wdata   <= 64'd0;
            bus.mem_sel     <= 1'b1;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.acerto      <= 1'b0;
            bus.afundou     <= 1'b0;
            bus.invalido    <= 1'b0;
            bus.jogador_out <= 1'b0;
        end else begin
            bus.done   <= 1'b0;
            bus.mem_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        shot            <= bus.tiro;
                        bus.jogador_out <= bus.jogador;
                        bus.mem_sel     <= ~bus.jogador;
                        bus.busy        <= 1'b1;
                        bus.acerto      <= 1'b0;
                        bus.afundou     <= 1'b0;
                        bus.invalido    <= 1'b0;
                        state           <= CHECK;
                    end
                end
                CHECK: begin
                    if (shot == 5'd0) begin
                        bus.invalido <= 1'b1;
                        state        <= FINISH;
                    end else begin
                        bus.mem_addr <= 5'd0;
                        state        <= READ;
                    end
                end
                READ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    state <= COMPARE;
                end
                COMPARE: begin
                    if (hit) begin
                        bus.mem_wdata <= cleared;
                        bus.mem_we    <= 1'b1;
                        bus.acerto    <= 1'b1;
                        state         <= WRITE;
                    end else if (bus.mem_addr < 5'd11) begin
                        bus.mem_addr <= bus.mem_addr + 5'd1;
                        state        <= READ;
                    end else begin
                        state <= FINISH;
                    end
                end
                WRITE: begin
                    bus.afundou <= (bus.mem_wdata[42:3] == 40'd0);
                    state       <= FINISH;
                end
                FINISH: begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shot_resolver.sv
// Bench for shot_resolver: fleet memory model, timing model, per-cycle compare.
// Directed shots with hand-computed latencies and write-back words.
module tb_shot_resolver;
    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;

    shot_resolver_if bus ();

    shot_resolver dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] mem     [2][12];
    logic [63:0] exp_mem [2][12];
    logic        load_req;

    // Synchronous-read fleet memories, written on the strobe
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 12; j++)
                    mem[i][j] <= exp_mem[i][j];
        end else if (bus.mem_we && bus.mem_addr < 5'd12) begin
            mem[bus.mem_sel][bus.mem_addr] <= bus.mem_wdata;
        end
        if (bus.mem_addr < 5'd12)
            bus.mem_rdata <= mem[bus.mem_sel][bus.mem_addr];
        else
            bus.mem_rdata <= 64'd0;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // Shot rule: every live cell equal to the shot is destroyed
    function automatic logic [63:0] strike(input logic [63:0] w,
                                           input logic [4:0] t);
        logic [63:0] r;
        r = w;
        for (int k = 0; k < 8; k++)
            if (t != 5'd0 && w[3+5*k +: 5] == t)
                r[3+5*k +: 5] = 5'd0;
        return r;
    endfunction

    // Model state: 0 unknown, 1 reset values, 2 operation started at t0
    int          mode;
    int          t0;
    int          len;
    int          we_at;
    int          hit_addr;
    int          last_addr;
    logic [63:0] exp_wdata;
    logic        exp_ac, exp_af, exp_inv, exp_sel, exp_jog;
    logic [4:0]  exp_addr_final;
    logic        is_inv;

    int          done_rel;
    logic [63:0] last_wdata;
    logic [15:0] mask;

    // Compare DUT outputs against the model every cycle
    always @(negedge clk) begin : cmp
        int rel;
        if (mode == 1) begin
            chk("rst_busy", 64'(bus.busy), 64'd0);
            chk("rst_done", 64'(bus.done), 64'd0);
            chk("rst_we", 64'(bus.mem_we), 64'd0);
            chk("rst_sel", 64'(bus.mem_sel), 64'd1);
            chk("rst_jog", 64'(bus.jogador_out), 64'd0);
            chk("rst_acerto", 64'(bus.acerto), 64'd0);
            chk("rst_afundou", 64'(bus.afundou), 64'd0);
            chk("rst_invalido", 64'(bus.invalido), 64'd0);
            chk("rst_addr", 64'(bus.mem_addr), 64'd0);
            chk("rst_wdata", bus.mem_wdata, 64'd0);
        end else if (mode == 2) begin
            rel = cyc - t0;
            if (rel == 0) begin
                mask     = 16'd0;
                done_rel = -1;
            end
            chk("busy", 64'(bus.busy), 64'(rel < len));
            chk("done", 64'(bus.done), 64'(rel == len));
            chk("mem_we", 64'(bus.mem_we), 64'(we_at >= 0 && rel == we_at));
            chk("mem_sel", 64'(bus.mem_sel), 64'(exp_sel));
            chk("jogador_out", 64'(bus.jogador_out), 64'(exp_jog));
            if (bus.mem_we) begin
                last_wdata = bus.mem_wdata;
                chk("we_addr", 64'(bus.mem_addr), 64'(hit_addr));
                chk("we_data", bus.mem_wdata, exp_wdata);
            end
            if (bus.done && done_rel < 0)
                done_rel = rel;
            if (is_inv)
                chk("inv_addr", 64'(bus.mem_addr), 64'(exp_addr_final));
            if (!is_inv && rel >= 1 && rel < len) begin
                if (bus.mem_addr < 5'd12)
                    mask = mask | (16'd1 << bus.mem_addr);
                else
                    mask = mask | 16'h8000;
            end
            if (!is_inv && rel == len)
                chk("scan_set", 64'(mask),
                    64'((32'd1 << (last_addr + 1)) - 1));
            if (rel >= len) begin
                chk("acerto", 64'(bus.acerto), 64'(exp_ac));
                chk("afundou", 64'(bus.afundou), 64'(exp_af));
                chk("invalido", 64'(bus.invalido), 64'(exp_inv));
                chk("idle_addr", 64'(bus.mem_addr), 64'(exp_addr_final));
            end
        end
    end

    task automatic launch(input logic jog, input logic [4:0] t,
                          output int s, output int l);
        int          h;
        logic [63:0] nw;
        s  = jog ? 0 : 1;
        h  = -1;
        nw = 64'd0;
        if (t != 5'd0)
            for (int i = 0; i < 12; i++)
                if (h < 0 && strike(exp_mem[s][i], t) != exp_mem[s][i]) begin
                    h  = i;
                    nw = strike(exp_mem[s][i], t);
                end
        l = (t == 5'd0) ? 2 : (h >= 0) ? 3 * h + 6 : 38;
        bus.jogador = jog;
        bus.tiro    = t;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.tiro    = ~t;
        bus.jogador = ~jog;
        t0        = cyc;
        len       = l;
        we_at     = (h >= 0) ? 3 * h + 4 : -1;
        hit_addr  = h;
        exp_wdata = nw;
        exp_ac    = (h >= 0);
        exp_af    = (h >= 0) && (nw[42:3] == 40'd0);
        exp_inv   = (t == 5'd0);
        is_inv    = (t == 5'd0);
        exp_sel   = ~jog;
        exp_jog   = jog;
        if (t != 5'd0) begin
            last_addr      = (h >= 0) ? h : 11;
            exp_addr_final = 5'(last_addr);
        end
        if (h >= 0)
            exp_mem[s][h] = nw;
        mode = 2;
    endtask

    task automatic check_mem();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 12; j++)
                chk($sformatf("mem_%0d_%0d", i, j), mem[i][j], exp_mem[i][j]);
    endtask

    task automatic run_shot(input logic jog, input logic [4:0] t,
                            input int pulse_at);
        int s, l;
        launch(jog, t, s, l);
        repeat (l + 2) begin
            @(posedge clk);
            #1;
            bus.start = (pulse_at >= 0 && cyc - t0 == pulse_at);
        end
        bus.start = 1'b0;
        chk("latency", 64'(done_rel), 64'(l));
        check_mem();
    endtask

    initial begin
        int s, l;
        checks    = 0;
        failures  = 0;
        mode      = 0;
        exp_addr_final = 5'd0;
        last_addr = 0;
        bus.start   = 1'b0;
        bus.jogador = 1'b0;
        bus.tiro    = 5'd0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 12; j++)
                exp_mem[i][j] = 64'd0;
        exp_mem[1][0] = 64'd9 << 3;
        exp_mem[1][2] = 64'h0000_0000_0014_0928;
        exp_mem[1][3] = 64'hABCD_0000_0000_083D;
        exp_mem[1][6] = 64'd5 << 3;
        exp_mem[1][9] = 64'hFFFF_F800_0000_0007;
        exp_mem[0][0] = 64'h8000_0000_0600_0002;
        reset    = 1'b0;
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        mode     = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("init_busy", 64'(bus.busy), 64'd0);
        chk("init_sel", 64'(bus.mem_sel), 64'd1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_shot(1'b0, 5'd7, -1);
        chk("t035_lat", 64'(done_rel), 64'd15);
        chk("t035_wdata", last_wdata, 64'hABCD_0000_0000_0805);
        chk("t035_acerto", 64'(bus.acerto), 64'd1);
        chk("t035_afundou", 64'(bus.afundou), 64'd0);
        chk("t035_sel", 64'(bus.mem_sel), 64'd1);

        run_shot(1'b1, 5'd12, -1);
        chk("t036_lat", 64'(done_rel), 64'd6);
        chk("t036_wdata", last_wdata, 64'h8000_0000_0000_0002);
        chk("t036_afundou", 64'(bus.afundou), 64'd1);
        chk("t036_sel", 64'(bus.mem_sel), 64'd0);

        run_shot(1'b1, 5'd20, -1);
        chk("t037_lat", 64'(done_rel), 64'd38);
        chk("t037_reads", 64'(mask), 64'h0FFF);
        chk("t037_acerto", 64'(bus.acerto), 64'd0);

        run_shot(1'b0, 5'd0, -1);
        chk("t038_lat", 64'(done_rel), 64'd2);
        chk("t038_invalido", 64'(bus.invalido), 64'd1);
        chk("t038_addr", 64'(bus.mem_addr), 64'd11);

        run_shot(1'b0, 5'd5, 5);
        chk("t039_lat", 64'(done_rel), 64'd12);
        chk("t039_wdata", last_wdata, 64'h0000_0000_0000_0900);
        chk("t039_e6", mem[1][6], 64'd40);

        launch(1'b0, 5'd20, s, l);
        while (cyc < t0 + 14) begin
            @(posedge clk);
            #1;
        end
        chk("t040_addr", 64'(bus.mem_addr), 64'd4);
        reset     = 1'b0;
        bus.start = 1'b1;
        bus.tiro  = 5'd7;
        @(posedge clk);
        #1;
        mode = 1;
        @(posedge clk);
        #1;
        reset     = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t040_busy", 64'(bus.busy), 64'd0);
        check_mem();

        run_shot(1'b0, 5'd8, -1);
        chk("tfin_lat", 64'(done_rel), 64'd15);
        chk("tfin_wdata", last_wdata, 64'hABCD_0000_0000_0005);
        chk("tfin_afundou", 64'(bus.afundou), 64'd1);

        mode = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
